// File: rtl/gs_pkg.sv
// Shared constants and read-sequencer state encoding for the Gaussian
// line ping-pong controller.
package gs_pkg;

  localparam int GS_DW     = 8;
  localparam int GS_WIDTH  = 256;
  localparam int GS_HEIGHT = 256;
  localparam int GS_AW     = 8;
  // Flush reads repeat the last pixel so the blur pipeline (KERNEL taps) drains.
  localparam int GS_KERNEL = 5;
  localparam int GS_PAD    = GS_KERNEL - 1;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_FLUSH = 2'd2
  } rd_state_t;

  // One-hot bank mask used for bank_full set/clear.
  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gs_line_rd_seq.sv
// Read sequencer: walks a full bank for WIDTH reads plus PAD flush reads of
// the last pixel, then frees the bank and moves to the other one.
module gs_line_rd_seq
  import gs_pkg::*;
#(
  parameter int WIDTH  = GS_WIDTH,
  parameter int HEIGHT = GS_HEIGHT,
  parameter int PAD    = GS_PAD,
  parameter int AW     = GS_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    bank_full,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          re0,
  output logic          re1,
  output logic          rd_valid0,
  output logic          rd_valid1,
  output logic          rd_done,
  output logic [AW:0]   line_cnt,
  output logic          frame_done
);

  localparam int PW = (PAD > 1) ? $clog2(PAD) : 1;
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);
  localparam logic [PW-1:0] PAD_LAST  = PW'(PAD - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);

  rd_state_t     state_r;
  logic          rd_bank_r;
  logic [AW-1:0] rd_addr_r;
  logic [PW-1:0] pad_cnt_r;
  logic [AW:0]   line_cnt_r;
  logic          frame_done_r;
  logic          rd_valid0_r;
  logic          rd_valid1_r;
  logic          active_s;

  assign active_s   = (state_r != RD_IDLE);
  assign re0        = active_s && !rd_bank_r;
  assign re1        = active_s && rd_bank_r;
  assign rd_done    = (state_r == RD_FLUSH) && (pad_cnt_r == PAD_LAST);
  assign rd_bank    = rd_bank_r;
  assign rd_addr    = rd_addr_r;
  assign rd_valid0  = rd_valid0_r;
  assign rd_valid1  = rd_valid1_r;
  assign line_cnt   = line_cnt_r;
  assign frame_done = frame_done_r;

  // Read FSM, line/frame accounting and the one-cycle read-valid delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RD_IDLE;
      rd_bank_r    <= 1'b0;
      rd_addr_r    <= '0;
      pad_cnt_r    <= '0;
      line_cnt_r   <= '0;
      frame_done_r <= 1'b0;
      rd_valid0_r  <= 1'b0;
      rd_valid1_r  <= 1'b0;
    end else begin
      rd_valid0_r  <= re0;
      rd_valid1_r  <= re1;
      frame_done_r <= 1'b0;
      case (state_r)
        RD_IDLE: begin
          if (bank_full[rd_bank_r]) begin
            state_r   <= RD_READ;
            rd_addr_r <= '0;
          end else begin
            state_r   <= RD_IDLE;
          end
        end
        RD_READ: begin
          if (rd_addr_r == LAST_ADDR) begin
            state_r   <= RD_FLUSH;
            pad_cnt_r <= '0;
          end else begin
            rd_addr_r <= rd_addr_r + 1'b1;
          end
        end
        RD_FLUSH: begin
          // rd_addr stays on the last pixel for the whole flush.
          if (pad_cnt_r == PAD_LAST) begin
            state_r   <= RD_IDLE;
            rd_bank_r <= ~rd_bank_r;
            rd_addr_r <= '0;
            if (line_cnt_r == LAST_LINE) begin
              line_cnt_r   <= '0;
              frame_done_r <= 1'b1;
            end else begin
              line_cnt_r   <= line_cnt_r + 1'b1;
            end
          end else begin
            pad_cnt_r <= pad_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/gs_line_pingpong_ctrl.sv
// Ping-pong line buffer controller: writes raster lines into alternating
// banks and hands completed banks to the read sequencer.
module gs_line_pingpong_ctrl
  import gs_pkg::*;
#(
  parameter int WIDTH  = GS_WIDTH,
  parameter int HEIGHT = GS_HEIGHT,
  parameter int PAD    = GS_PAD,
  parameter int AW     = GS_AW,
  parameter int DW     = GS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          ram0_we,
  output logic          ram0_re,
  output logic [AW-1:0] ram0_addr,
  output logic [DW-1:0] ram0_wdata,
  output logic          ram1_we,
  output logic          ram1_re,
  output logic [AW-1:0] ram1_addr,
  output logic [DW-1:0] ram1_wdata,
  output logic          ram0_rd_valid,
  output logic          ram1_rd_valid,
  output logic [AW:0]   line_cnt,
  output logic          frame_done
);

  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);

  logic          wr_bank_r;
  logic [AW-1:0] wr_addr_r;
  logic [1:0]    bank_full_r;
  logic [AW:0]   wr_line_r;
  logic          wr_fire_s;
  logic          wr_eol_s;
  logic [1:0]    wr_set_s;
  logic [1:0]    rd_clr_s;
  logic          rd_bank_s;
  logic [AW-1:0] rd_addr_s;
  logic          rd_done_s;

  gs_line_rd_seq #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .PAD   (PAD),
    .AW    (AW)
  ) u_rd_seq (
    .clk       (clk),
    .rst       (rst),
    .bank_full (bank_full_r),
    .rd_bank   (rd_bank_s),
    .rd_addr   (rd_addr_s),
    .re0       (ram0_re),
    .re1       (ram1_re),
    .rd_valid0 (ram0_rd_valid),
    .rd_valid1 (ram1_rd_valid),
    .rd_done   (rd_done_s),
    .line_cnt  (line_cnt),
    .frame_done(frame_done)
  );

  // A bank being written is never full, so writer and reader never share a bank.
  assign pix_ready  = !bank_full_r[wr_bank_r];
  assign wr_fire_s  = pix_valid && pix_ready;
  assign wr_eol_s   = wr_fire_s && (wr_addr_r == LAST_ADDR);
  assign ram0_we    = wr_fire_s && !wr_bank_r;
  assign ram1_we    = wr_fire_s && wr_bank_r;
  assign ram0_wdata = ram0_we ? pix_data : '0;
  assign ram1_wdata = ram1_we ? pix_data : '0;
  assign ram0_addr  = ram0_re ? rd_addr_s : wr_addr_r;
  assign ram1_addr  = ram1_re ? rd_addr_s : wr_addr_r;
  assign wr_set_s   = wr_eol_s  ? bank_onehot(wr_bank_r) : 2'b00;
  assign rd_clr_s   = rd_done_s ? bank_onehot(rd_bank_s) : 2'b00;

  // Write address/bank sequencing and bank_full bookkeeping (set and clear
  // on different banks in the same cycle both take effect).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r   <= 1'b0;
      wr_addr_r   <= '0;
      bank_full_r <= 2'b00;
      wr_line_r   <= '0;
    end else begin
      bank_full_r <= (bank_full_r & ~rd_clr_s) | wr_set_s;
      if (wr_eol_s) begin
        wr_addr_r <= '0;
        wr_bank_r <= ~wr_bank_r;
        wr_line_r <= (wr_line_r == LAST_LINE) ? '0 : wr_line_r + 1'b1;
      end else if (wr_fire_s) begin
        wr_addr_r <= wr_addr_r + 1'b1;
      end else begin
        wr_addr_r <= wr_addr_r;
      end
    end
  end

endmodule

// File: tb/tb_gs_line_pingpong_ctrl.sv
// Scoreboard bench for gs_line_pingpong_ctrl with behavioural bank RAMs.
module tb_gs_line_pingpong_ctrl;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int PAD = 4;
  localparam int AW  = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          ram0_we, ram0_re, ram1_we, ram1_re;
  logic [AW-1:0] ram0_addr, ram1_addr;
  logic [DW-1:0] ram0_wdata, ram1_wdata;
  logic          ram0_rd_valid, ram1_rd_valid;
  logic [AW:0]   line_cnt;
  logic          frame_done;

  int vectors = 0;
  int errs    = 0;

  // Expected write, read-address and read-data events: (bank<<16)|(addr<<8)|data.
  int wq[$];
  int rq[$];
  int vq[$];

  bit in_reset;
  int k_acc;
  logic [DW-1:0] line_px [W];
  logic [DW-1:0] mem0 [W];
  logic [DW-1:0] mem1 [W];
  logic [DW-1:0] rdata0, rdata1;

  int w_lines, r_lines, run_len;
  bit prev_re;

  gs_line_pingpong_ctrl #(.WIDTH(W), .HEIGHT(H), .PAD(PAD), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ram0_we(ram0_we), .ram0_re(ram0_re), .ram0_addr(ram0_addr), .ram0_wdata(ram0_wdata),
    .ram1_we(ram1_we), .ram1_re(ram1_re), .ram1_addr(ram1_addr), .ram1_wdata(ram1_wdata),
    .ram0_rd_valid(ram0_rd_valid), .ram1_rd_valid(ram1_rd_valid),
    .line_cnt(line_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous-read line RAMs.
  always @(posedge clk) begin
    if (ram0_we) mem0[ram0_addr] <= ram0_wdata;
    if (ram1_we) mem1[ram1_addr] <= ram1_wdata;
    if (ram0_re) rdata0 <= mem0[ram0_addr];
    if (ram1_re) rdata1 <= mem1[ram1_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k-th accepted pixel goes to bank (k/W)%2 at addr k%W; a complete
  // line is read back as addr 0..W-1 then W-1 repeated PAD times.
  task automatic push_pixel(input logic [DW-1:0] d);
    int bank, addr, a;
    bank = (k_acc / W) % 2;
    addr = k_acc % W;
    wq.push_back((bank << 16) | (addr << 8) | int'(d));
    line_px[addr] = d;
    if (addr == W - 1) begin
      for (int i = 0; i < W + PAD; i++) begin
        a = (i < W) ? i : W - 1;
        rq.push_back((bank << 16) | (a << 8));
        vq.push_back((bank << 16) | int'(line_px[a]));
      end
    end
    k_acc++;
  endtask

  task automatic send_lines(input int n, input int gap, input bit ramp);
    int sent, budget;
    bit pend;
    logic [DW-1:0] d;
    sent = 0; pend = 1'b0; budget = n * W * 20 + 200; d = '0;
    while (sent < n * W) begin
      @(posedge clk); #1;
      if (!pend && ($urandom_range(99) >= gap)) begin
        pend = 1'b1;
        d = ramp ? DW'(sent) : DW'($urandom_range(255));
      end
      pix_valid = pend;
      pix_data  = d;
      if (pend && pix_ready) begin
        push_pixel(d);
        pend = 1'b0;
        sent++;
      end
      budget--;
      if (budget == 0) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((wq.size() != 0 || rq.size() != 0 || vq.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_pending", wq.size() + rq.size() + vq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_we", {ram0_we, ram1_we}, 0);
    chk("rst_re", {ram0_re, ram1_re}, 0);
    chk("rst_rd_valid", {ram0_rd_valid, ram1_rd_valid}, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_addr", {ram0_addr, ram1_addr}, 0);
  endtask

  // Monitor: pops and compares expected events whenever the DUT presents them.
  always @(negedge clk) begin
    int e;
    logic re_any;
    if (in_reset) begin
      wq.delete(); rq.delete(); vq.delete();
      w_lines = 0; r_lines = 0; run_len = 0; prev_re = 1'b0;
    end else begin
      re_any = ram0_re | ram1_re;
      chk("re_exclusive", ram0_re & ram1_re, 0);
      chk("rd_valid_exclusive", ram0_rd_valid & ram1_rd_valid, 0);
      if (prev_re && !re_any) begin
        chk("read_len", run_len, W + PAD);
        r_lines++;
        chk("frame_done", frame_done, (r_lines % H) == 0);
        chk("line_cnt", line_cnt, r_lines % H);
        run_len = 0;
      end else begin
        chk("frame_done_quiet", frame_done, 0);
      end
      if (re_any) begin
        run_len++;
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_bank", ram1_re, e >> 16);
          chk("rd_addr", ram1_re ? ram1_addr : ram0_addr, (e >> 8) & 255);
        end
      end
      chk("pix_ready", pix_ready, (w_lines - r_lines) < 2);
      chk("we_exclusive", ram0_we & ram1_we, 0);
      if (ram0_we | ram1_we) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_bank", ram1_we, e >> 16);
          chk("wr_addr", ram1_we ? ram1_addr : ram0_addr, (e >> 8) & 255);
          chk("wr_data", ram1_we ? ram1_wdata : ram0_wdata, e & 255);
          if (((e >> 8) & 255) == W - 1) w_lines++;
        end
      end
      if (ram0_rd_valid | ram1_rd_valid) begin
        if (vq.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          e = vq.pop_front();
          chk("rv_bank", ram1_rd_valid, e >> 16);
          chk("rv_data", ram1_rd_valid ? rdata1 : rdata0, e & 255);
        end
      end
      prev_re = re_any;
    end
  end

  initial begin
    int budget;
    rst = 1'b1; in_reset = 1'b1; pix_valid = 1'b0; pix_data = '0; k_acc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0; in_reset = 1'b0;

    send_lines(1, 0, 1'b1);     // ramp line 0..7 into bank0
    drain();
    send_lines(3, 0, 1'b0);     // continuous: writer catches reader, backpressure
    drain();
    send_lines(4, 50, 1'b0);    // random gaps
    drain();

    // Reset in the middle of a bank0 read.
    send_lines(1, 0, 1'b0);
    budget = 500;
    while (!(ram0_re && ram0_addr == 3'd3) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("mid_read_reached", budget > 0, 1);
    in_reset = 1'b1; rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0; k_acc = 0; in_reset = 1'b0;

    send_lines(2, 30, 1'b0);    // resumes at bank0 addr 0
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
